// File: rtl/frame_streamer_if.sv
// Frame-buffer read port and pixel stream bundled between the streamer
// (master) and the buffer/sink side (slave).
interface frame_streamer_if #(
    parameter int PIX_W  = 8,
    parameter int CHAN_W = 2,
    parameter int ADDR_W = 13
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;

    logic              m_valid;
    logic              m_ready;
    logic [PIX_W-1:0]  m_data;
    logic [CHAN_W-1:0] m_chan;
    logic              m_sof;
    logic              m_eol;
    logic              m_eof;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output m_valid, m_data, m_chan, m_sof, m_eol, m_eof,
        input  m_ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  m_valid, m_data, m_chan, m_sof, m_eol, m_eof,
        output m_ready
    );
endinterface

// File: rtl/frame_streamer.sv
// Waits for every plane of a frame to report done, then reads the planar
// frame buffer in address order and emits it as a valid/ready pixel stream
// with frame/line markers.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | collecting done flags, arms when en and all flags are set
// STREAM | issuing buffer reads, one per cycle while the FIFO has room
// DRAIN  | last read issued, waiting for the eof beat to be accepted
module frame_streamer #(
    parameter int LENGTH     = 64,
    parameter int WIDTH      = 64,
    parameter int CHANNELS   = 3,
    parameter int PIX_W      = 8,
    parameter int CHROMA_SUB = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CHANNELS-1:0] done_in,
    output logic                busy,
    output logic                write_done,
    output logic [15:0]         frame_cnt,
    frame_streamer_if.master    bus
);
    localparam int C_LEN   = (CHROMA_SUB != 0) ? (LENGTH >> 1) : LENGTH;
    localparam int C_WID   = (CHROMA_SUB != 0) ? (WIDTH >> 1) : WIDTH;
    localparam int LUMA_SZ = LENGTH * WIDTH;
    localparam int CHR_SZ  = C_LEN * C_WID;
    localparam int TOTAL   = LUMA_SZ + (CHANNELS - 1) * CHR_SZ;
    localparam int ADDR_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int COL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int LIN_W   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

    if (CHROMA_SUB != 0 && ((LENGTH % 2) != 0 || (WIDTH % 2) != 0)) begin : g_bad_sub
        $error("frame_streamer: 4:2:0 chroma needs even LENGTH and WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic              sof;
        logic              eol;
        logic              eof;
    } mark_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        mark_t            mark;
    } beat_t;

    state_t              state_q, state_d;
    logic [CHANNELS-1:0] flags_q, flags_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LIN_W-1:0]    line_q, line_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic                inflight_q, inflight_d;
    mark_t               mark_q, mark_d;
    beat_t               fifo_q [2];
    beat_t               fifo_d [2];
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                write_done_q, write_done_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic [CHANNELS-1:0] flags_all;
    logic                arm;
    logic                pop;
    logic                issue;
    logic [2:0]          level;
    logic [COL_W-1:0]    last_col;
    logic [LIN_W-1:0]    last_line;
    beat_t               head;

    // Read pacing, raster/plane counters, marker tagging, FIFO and FSM next state.
    always_comb begin
        flags_all = flags_q | done_in;
        arm       = (state_q == S_IDLE) && en && (&flags_all);
        head      = fifo_q[rd_ptr_q];
        pop       = (cnt_q != 2'd0) && bus.m_ready;
        // A read lands one cycle later, so count it against FIFO space now.
        level     = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
        issue     = (state_q == S_STREAM) && (level < 3'd2);
        last_col  = (chan_q == '0) ? COL_W'(WIDTH - 1) : COL_W'(C_WID - 1);
        last_line = (chan_q == '0) ? LIN_W'(LENGTH - 1) : LIN_W'(C_LEN - 1);

        state_d      = state_q;
        flags_d      = flags_all;
        addr_d       = addr_q;
        col_d        = col_q;
        line_d       = line_q;
        chan_d       = chan_q;
        inflight_d   = issue;
        mark_d       = mark_q;
        fifo_d       = fifo_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = 2'(cnt_q + {1'b0, inflight_q} - {1'b0, pop});
        write_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        if (issue) begin
            mark_d.chan = chan_q;
            mark_d.sof  = (addr_q == '0);
            mark_d.eol  = (col_q == last_col);
            mark_d.eof  = (addr_q == LAST_ADDR);
            addr_d      = addr_q + 1'b1;
            if (col_q == last_col) begin
                col_d = '0;
                if (line_q == last_line) begin
                    line_d = '0;
                    chan_d = chan_q + 1'b1;
                end else begin
                    line_d = line_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (inflight_q) begin
            fifo_d[wr_ptr_q] = {bus.rd_data, mark_q};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_STREAM;
                    flags_d = '0;
                    addr_d  = '0;
                    col_d   = '0;
                    line_d  = '0;
                    chan_d  = '0;
                end
            end
            S_STREAM: begin
                if (issue && addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end
            end
            S_DRAIN: begin
                if (pop && head.mark.eof) begin
                    state_d      = S_IDLE;
                    write_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and FIFO registers; reset drops any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            flags_q      <= '0;
            addr_q       <= '0;
            col_q        <= '0;
            line_q       <= '0;
            chan_q       <= '0;
            inflight_q   <= 1'b0;
            mark_q       <= '0;
            fifo_q       <= '{default: '0};
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            cnt_q        <= 2'd0;
            write_done_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            addr_q       <= addr_d;
            col_q        <= col_d;
            line_q       <= line_d;
            chan_q       <= chan_d;
            inflight_q   <= inflight_d;
            mark_q       <= mark_d;
            fifo_q       <= fifo_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            write_done_q <= write_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign bus.rd_en   = issue;
    assign bus.rd_addr = addr_q;
    assign bus.m_valid = (cnt_q != 2'd0);
    assign bus.m_data  = head.data;
    assign bus.m_chan  = head.mark.chan;
    assign bus.m_sof   = bus.m_valid & head.mark.sof;
    assign bus.m_eol   = bus.m_valid & head.mark.eol;
    assign bus.m_eof   = bus.m_valid & head.mark.eof;
    assign busy        = (state_q != S_IDLE);
    assign write_done  = write_done_q;
    assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench: 4x4 three-plane 4:2:0 streamer plus a 4x4 two-plane 4:4:4 one.
`timescale 1ns/1ps
module tb_frame_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] done_in = 3'b000;
    logic [1:0] done2 = 2'b00;
    logic       busy, write_done, busy2, write_done2;
    logic [15:0] frame_cnt, frame_cnt2;

    frame_streamer_if #(.PIX_W(8), .CHAN_W(2), .ADDR_W(5)) bus1 ();
    frame_streamer_if #(.PIX_W(8), .CHAN_W(1), .ADDR_W(5)) bus2 ();

    frame_streamer #(.LENGTH(4), .WIDTH(4), .CHANNELS(3), .PIX_W(8), .CHROMA_SUB(1)) dut (
        .clk(clk), .rst(rst), .en(en), .done_in(done_in), .busy(busy),
        .write_done(write_done), .frame_cnt(frame_cnt), .bus(bus1)
    );

    frame_streamer #(.LENGTH(4), .WIDTH(4), .CHANNELS(2), .PIX_W(8), .CHROMA_SUB(0)) dut2 (
        .clk(clk), .rst(rst), .en(en), .done_in(done2), .busy(busy2),
        .write_done(write_done2), .frame_cnt(frame_cnt2), .bus(bus2)
    );

    function automatic logic [7:0] pix(input int a);
        return 8'(a * 7 + 3);
    endfunction

    // frame buffers answer one cycle after the read strobe
    always @(posedge clk) if (bus1.rd_en) bus1.rd_data <= pix(int'(bus1.rd_addr));
    always @(posedge clk) if (bus2.rd_en) bus2.rd_data <= pix(int'(bus2.rd_addr));

    int errors = 0;
    int checks = 0;

    logic [7:0] cap_data [64];
    logic [1:0] cap_chan [64];
    logic       cap_sof  [64];
    logic       cap_eol  [64];
    logic       cap_eof  [64];
    int nbeats, first_rd, first_v, rd_bad, stall_bad, max_out, wd_cnt, timeout, issued;

    task automatic collect(input logic en_val, input int d0s, input int d1s, input int d2s,
                           input int rmode, input int extra_beat, input int stop_beats,
                           input int max_steps);
        int accepted, exp_addr;
        logic have_stall, sent, fin;
        logic [12:0] st, cur;
        nbeats = 0; first_rd = -1; first_v = -1; rd_bad = 0; stall_bad = 0;
        max_out = 0; wd_cnt = 0; timeout = 0; issued = 0;
        accepted = 0; exp_addr = 0; have_stall = 0; sent = 0; fin = 0; st = '0;
        for (int s = 0; s < max_steps; s++) begin
            @(negedge clk);
            en = en_val;
            done_in = {(s == d2s), (s == d1s), (s == d0s)};
            if (extra_beat >= 0 && !sent && nbeats >= extra_beat) begin
                done_in = 3'b111;
                sent = 1'b1;
            end
            bus1.m_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            #1;
            if (bus1.rd_en) begin
                if (first_rd < 0) first_rd = s;
                if (int'(bus1.rd_addr) != exp_addr) rd_bad++;
                exp_addr++;
                issued++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            cur = {bus1.m_data, bus1.m_chan, bus1.m_sof, bus1.m_eol, bus1.m_eof};
            if (have_stall && (!bus1.m_valid || cur != st)) stall_bad++;
            have_stall = 1'b0;
            if (bus1.m_valid) begin
                if (first_v < 0) first_v = s;
                if (bus1.m_ready) begin
                    if (nbeats < 64) begin
                        cap_data[nbeats] = bus1.m_data;
                        cap_chan[nbeats] = bus1.m_chan;
                        cap_sof[nbeats]  = bus1.m_sof;
                        cap_eol[nbeats]  = bus1.m_eol;
                        cap_eof[nbeats]  = bus1.m_eof;
                    end
                    nbeats++;
                    accepted++;
                end else begin
                    st = cur;
                    have_stall = 1'b1;
                end
            end
            if (write_done) wd_cnt++;
            if (wd_cnt > 0 || (stop_beats > 0 && nbeats >= stop_beats)) begin
                fin = 1'b1;
                break;
            end
        end
        done_in = 3'b000;
        if (!fin) timeout = 1;
    endtask

    // first beat (1-based) that differs from the 4x4x3 4:2:0 layout, -1 if none
    function automatic int first_bad(input int nb);
        for (int b = 1; b <= nb && b <= 64; b++) begin
            logic [7:0] d;
            logic [1:0] ch;
            logic       eol;
            d   = pix(b - 1);
            ch  = (b <= 16) ? 2'd0 : (b <= 20) ? 2'd1 : 2'd2;
            eol = (b <= 16) ? ((b % 4) == 0) : (((b - 16) % 2) == 0);
            if (cap_data[b-1] !== d || cap_chan[b-1] !== ch || cap_sof[b-1] !== (b == 1) ||
                cap_eol[b-1] !== eol || cap_eof[b-1] !== (b == 24))
                return b;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; done_in = '0; done2 = '0;
        bus1.m_ready = 1'b0; bus2.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus1.m_valid, bus1.rd_en, busy, write_done, bus1.m_sof, bus1.m_eol, bus1.m_eof} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus1.m_valid, bus1.rd_en, busy, write_done, bus1.m_sof, bus1.m_eol, bus1.m_eof});
        end
        checks++;
        if (frame_cnt !== 16'd0 || bus1.rd_addr !== 5'd0 || bus1.m_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: frame_cnt=%0d rd_addr=%0d m_data=%0d expected all 0",
                     frame_cnt, bus1.rd_addr, bus1.m_data);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus1.rd_en, busy, bus1.m_valid, busy2} !== 4'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected 0000", {bus1.rd_en, busy, bus1.m_valid, busy2});
        end
    endtask

    task automatic check_frame(input string name, input int exp_fc);
        int fb;
        fb = first_bad(nbeats);
        checks++;
        if (timeout != 0) begin errors++; $display("FAIL %s_timeout: frame did not complete", name); end
        checks++;
        if (nbeats != 24) begin errors++; $display("FAIL %s_beats: got %0d expected 24", name, nbeats); end
        checks++;
        if (fb != -1) begin errors++; $display("FAIL %s_content: first wrong beat %0d expected none", name, fb); end
        checks++;
        if (rd_bad != 0 || issued != 24) begin
            errors++; $display("FAIL %s_rd_addr: bad=%0d reads=%0d expected 0 and 24", name, rd_bad, issued);
        end
        checks++;
        if (wd_cnt != 1) begin errors++; $display("FAIL %s_write_done: got %0d expected 1", name, wd_cnt); end
        checks++;
        if (frame_cnt !== 16'(exp_fc)) begin
            errors++; $display("FAIL %s_frame_cnt: got %0d expected %0d", name, frame_cnt, exp_fc);
        end
    endtask

    task automatic test_basic();
        collect(1'b1, 0, 0, 0, 0, -1, 0, 200);
        checks++;
        if (first_rd != 1) begin errors++; $display("FAIL basic_rd_latency: got %0d expected 1", first_rd); end
        checks++;
        if (first_v != 3) begin errors++; $display("FAIL basic_valid_latency: got %0d expected 3", first_v); end
        check_frame("basic", 1);
        @(negedge clk);
        #1;
        checks++;
        if ({write_done, busy} !== 2'b00) begin
            errors++; $display("FAIL basic_pulse_width: write_done,busy=%b expected 00", {write_done, busy});
        end
    endtask

    task automatic test_stagger();
        collect(1'b1, 9, 5, 14, 0, -1, 0, 200);
        checks++;
        if (first_rd != 15) begin errors++; $display("FAIL stagger_first_rd: got %0d expected 15", first_rd); end
        checks++;
        if (first_v != 17) begin errors++; $display("FAIL stagger_first_valid: got %0d expected 17", first_v); end
        check_frame("stagger", 2);
    endtask

    task automatic test_backpressure();
        collect(1'b1, 0, 0, 0, 1, -1, 0, 600);
        check_frame("backpressure", 3);
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", stall_bad); end
        checks++;
        if (max_out > 3) begin errors++; $display("FAIL bp_outstanding: got %0d expected <= 3", max_out); end
    endtask

    task automatic test_early_done();
        collect(1'b1, 0, 0, 0, 0, 10, 0, 200);
        check_frame("early_f1", 4);
        collect(1'b1, -1, -1, -1, 0, -1, 0, 200);
        checks++;
        if (first_rd != 0) begin errors++; $display("FAIL early_rearm: got %0d expected 0", first_rd); end
        check_frame("early_f2", 5);
    endtask

    task automatic test_en_gating();
        int rd_seen;
        rd_seen = 0;
        for (int s = 0; s < 12; s++) begin
            @(negedge clk);
            en = 1'b0;
            done_in = (s == 0) ? 3'b111 : 3'b000;
            bus1.m_ready = 1'b1;
            #1;
            if (bus1.rd_en || busy) rd_seen++;
        end
        done_in = 3'b000;
        checks++;
        if (rd_seen != 0) begin errors++; $display("FAIL en_gate_idle: got %0d active cycles expected 0", rd_seen); end
        collect(1'b1, -1, -1, -1, 0, -1, 0, 200);
        checks++;
        if (first_rd != 1) begin errors++; $display("FAIL en_gate_start: got %0d expected 1", first_rd); end
        check_frame("en_gate", 6);
    endtask

    task automatic test_reset_mid();
        int wd_seen;
        wd_seen = 0;
        collect(1'b1, 0, 0, 0, 0, -1, 7, 200);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus1.m_valid, bus1.rd_en, busy, write_done, bus1.m_eol} !== 5'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midreset_outputs: ctrl=%b frame_cnt=%0d expected 0",
                     {bus1.m_valid, bus1.rd_en, busy, write_done, bus1.m_eol}, frame_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            #1;
            if (write_done || busy) wd_seen++;
        end
        checks++;
        if (wd_seen != 0) begin errors++; $display("FAIL midreset_silent: got %0d expected 0", wd_seen); end
        collect(1'b1, 0, 0, 0, 0, -1, 0, 200);
        checks++;
        if (first_rd != 1) begin errors++; $display("FAIL midreset_restart: got %0d expected 1", first_rd); end
        check_frame("midreset", 1);
    endtask

    task automatic test_config();
        int nb2, bad2, wd2c, chan17;
        logic fin;
        nb2 = 0; bad2 = -1; wd2c = 0; chan17 = -1; fin = 1'b0;
        for (int s = 0; s < 150; s++) begin
            @(negedge clk);
            done2 = (s == 0) ? 2'b11 : 2'b00;
            bus2.m_ready = 1'b1;
            #1;
            if (bus2.m_valid) begin
                int b;
                b = nb2 + 1;
                if (b == 17) chan17 = int'(bus2.m_chan);
                if (bad2 < 0 && (bus2.m_data !== pix(b - 1) || bus2.m_chan !== ((b <= 16) ? 1'b0 : 1'b1) ||
                    bus2.m_eol !== ((b % 4) == 0) || bus2.m_sof !== (b == 1) || bus2.m_eof !== (b == 32)))
                    bad2 = b;
                nb2++;
            end
            if (write_done2) begin
                wd2c++;
                fin = 1'b1;
                break;
            end
        end
        done2 = 2'b00;
        checks++;
        if (!fin || nb2 != 32) begin errors++; $display("FAIL cfg444_beats: got %0d expected 32", nb2); end
        checks++;
        if (bad2 != -1) begin errors++; $display("FAIL cfg444_content: first wrong beat %0d expected none", bad2); end
        checks++;
        if (chan17 != 1) begin errors++; $display("FAIL cfg444_chan17: got %0d expected 1", chan17); end
        checks++;
        if (frame_cnt2 !== 16'd1) begin errors++; $display("FAIL cfg444_frame_cnt: got %0d expected 1", frame_cnt2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stagger();
        test_backpressure();
        test_early_done();
        test_en_gating();
        test_reset_mid();
        test_config();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Synthesizable successor to the simulation-only frame dump.
- Waits until every plane of a frame (luma plus N chroma planes) reports done, then reads the frame from a planar frame buffer.
- Emits the frame as a valid/ready pixel stream with frame and line markers, for capture by a debug sink or display path.
- Supports a configurable plane count, pixel width and 4:4:4 or 4:2:0 chroma layout, and pulses write_done when the last pixel is accepted.

Parameters:
- LENGTH, 64: lines per luma plane.
- WIDTH, 64: pixels per luma line.
- CHANNELS, 3: plane count. Plane 0 is luma; planes 1..CHANNELS-1 are chroma.
- PIX_W, 8: pixel width in bits.
- CHROMA_SUB, 1: chroma subsampling. 0 = chroma planes are LENGTH x WIDTH. 1 = chroma planes are (LENGTH>>1) x (WIDTH>>1).
- ADDR_W, derived: clog2(total pixels over all planes).

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- en, input, 1: permits arming a new frame.
- done_in, input, CHANNELS: per-plane completion pulses or levels. Bit 0 = luma.
- rd_en, output, 1: frame buffer read strobe.
- rd_addr, output, ADDR_W: frame buffer read address.
- rd_data, input, PIX_W: read data, valid the cycle after rd_en.
- m_valid, output, 1: stream beat valid.
- m_ready, input, 1: sink accepts.
- m_data, output, PIX_W: pixel.
- m_chan, output, clog2(CHANNELS) (min 1): plane index of the beat.
- m_sof, output, 1: first beat of the frame.
- m_eol, output, 1: last beat of a line.
- m_eof, output, 1: last beat of the frame.
- busy, output, 1: high in STREAM or DRAIN.
- write_done, output, 1: one-cycle pulse per completed frame.
- frame_cnt, output, 16: completed frames, wraps at 65535->0.

Behaviour:
- Reset (async): state IDLE, done flags 0, FIFO empty, nothing in flight. All outputs 0 and frame_cnt 0.
- Reset mid-frame aborts the frame silently: no write_done, no frame_cnt increment.
- Done flags are sticky. Every cycle: flags <= flags | done_in, in every state and regardless of en.
- IDLE -> STREAM when en=1 and (flags | done_in) is all ones.
  - On that cycle flags clear to 0; done_in bits of that cycle are consumed by this frame.
- Done pulses arriving during STREAM/DRAIN latch for the next frame.
- en deassertion mid-frame does not abort; it only blocks the next arm.
- Layout:
  - Planes are contiguous in buffer order 0..CHANNELS-1; plane c base = sum of earlier plane sizes.
  - Within a plane, raster order; rd_addr increments by 1 from 0 to TOTAL-1.
- STREAM: a read issues (rd_en=1) when occ + inflight - pop < 2, where:
  - occ = 2-entry output FIFO occupancy (0..2).
  - inflight = rd_en of the previous cycle.
  - pop = m_valid && m_ready.
  - This sustains 1 beat/cycle with m_ready held high and never overflows under backpressure.
- After the read of address TOTAL-1 issues: STREAM -> DRAIN.
- DRAIN -> IDLE on the handshake of the m_eof beat.
  - write_done pulses the following cycle; frame_cnt increments on the same edge as the pulse.
  - A re-arm is evaluated from that IDLE cycle onward.
- Latency: flags complete at cycle T -> rd_en at T+1 -> m_valid at T+3.
- Stream rules:
  - m_data and markers are held stable while m_valid && !m_ready.
  - m_valid never drops without a handshake.
  - Marker bits travel in the FIFO alongside the data.
- Markers:
  - m_sof is set on the plane-0 first beat only.
  - m_eol is set on the last pixel of every line of every plane, using that plane's line width.
  - m_eof is set on the final beat only and coincides with m_eol.
  - m_chan changes exactly at plane boundaries.
- Line and plane counters wrap column->0 at line end, and line->0 / chan+1 at plane end.
- CHANNELS=1 degenerates to luma-only. With CHROMA_SUB=1, LENGTH and WIDTH must be even (elaboration assertion).

Test Plan:
- Basic frame: LENGTH=4, WIDTH=4, CHANNELS=3, CHROMA_SUB=1, m_ready=1, done_in=3'b111 pulsed at cycle T.
  - rd_addr 0..23 on consecutive cycles; m_valid first at T+3; 24 beats, m_data = buffer[0..23].
  - m_eol on beats 4,8,12,16,18,20,22,24; m_chan 0 for beats 1-16, 1 for 17-20, 2 for 21-24.
  - m_eof on beat 24; write_done pulses once; frame_cnt=1.
- Staggered done: done_in[1] at cycle 5, done_in[0] at 9, done_in[2] at 14 -> first rd_en at 15; no read before then.
- Backpressure: m_ready random 50%.
  - Beat sequence identical to the basic-frame test; data stable while stalled; never more than 2 buffered + 1 in flight.
  - No beat lost or duplicated.
- Early next-frame done: done_in=3'b111 again during beat 10 of frame 1 -> frame 2 arms in the IDLE cycle after write_done; frame_cnt=2 after frame 2.
- en gating: en=0 with all done flags set -> stays IDLE, no rd_en. Raise en -> frame starts next cycle.
- Reset mid-frame: assert rst at beat 7.
  - All outputs 0 immediately; no write_done; frame_cnt=0.
  - After release, a new done_in=3'b111 yields a full 24-beat frame starting at rd_addr 0.
- Config CHROMA_SUB=0, CHANNELS=2, 4x4 -> 32 beats; m_eol every 4 beats; m_chan switches to 1 at beat 17.
